// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// aes_ctrl_pkg : shared types and helpers for the AES round controller
// Revision     : 1.0
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        KL128 = 2'd0,
        KL192 = 2'd1,
        KL256 = 2'd2,
        KLRSV = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    localparam logic [4:0] c_nr_128 = 5'd10;
    localparam logic [4:0] c_nr_192 = 5'd12;
    localparam logic [4:0] c_nr_256 = 5'd14;

    function automatic logic [4:0] nr_of(input key_len_e kl);
        logic [4:0] nr;
        case (kl)
            KL192:   nr = c_nr_192;
            KL256:   nr = c_nr_256;
            default: nr = c_nr_128;
        endcase
        return nr;
    endfunction

    function automatic logic mode_legal(input logic [1:0] kl, input logic [2:0] modes);
        logic ok;
        case (kl)
            2'd0:    ok = modes[0];
            2'd1:    ok = modes[1];
            2'd2:    ok = modes[2];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_counter.sv
// ============================================================================
// aes_round_counter : loadable round index counter with terminal compare
// Revision          : 1.0
// ============================================================================
`default_nettype none

module aes_round_counter
    import aes_ctrl_pkg::*;
#(
    parameter int RND_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [RND_W-1:0] i_nr,
    input  logic             i_dec,
    output logic [RND_W-1:0] o_idx,
    output logic [RND_W-1:0] o_key_idx,
    output logic             o_last
);

    logic [RND_W-1:0] r_idx;

    // Loading jumps straight to round 1: round 0 is applied alongside the load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= RND_W'(1);
        end else if (i_inc) begin
            r_idx <= r_idx + RND_W'(1);
        end
    end

    assign o_idx     = r_idx;
    assign o_last    = (r_idx == (i_nr - RND_W'(1)));
    assign o_key_idx = i_dec ? (i_nr - r_idx) : r_idx;

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// aes_round_ctrl : round sequencer for the iterative AES-128/192/256 datapath
// Revision       : 1.0
// ============================================================================
`default_nettype none

module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter logic [2:0] KEY_MODES  = 3'b111,
    parameter int         MAX_ROUNDS = 14,
    parameter int         RND_W      = $clog2(MAX_ROUNDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       key_len_i,
    input  logic             decrypt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             data_ld_o,
    output logic             round_en_o,
    output logic             final_round_o,
    output logic             out_ld_o,
    output logic [RND_W-1:0] round_idx_o,
    output logic [RND_W-1:0] key_idx_o,
    output logic             busy_o,
    output logic             err_o
);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    key_len_e         r_key_len;
    logic             r_dec;

    logic             w_legal;
    logic             w_accept;
    logic             w_inc;
    logic             w_last;
    logic [RND_W-1:0] w_nr_lat;
    logic [RND_W-1:0] w_nr_in;
    logic [RND_W-1:0] w_cnt_idx;
    logic [RND_W-1:0] w_cnt_key;

    assign w_legal  = mode_legal(key_len_i, KEY_MODES);
    assign w_nr_lat = RND_W'(nr_of(r_key_len));
    assign w_nr_in  = RND_W'(nr_of(key_len_e'(key_len_i)));
    assign w_inc    = (r_state == ROUND);

    aes_round_counter #(
        .RND_W (RND_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_load    (w_accept),
        .i_inc     (w_inc),
        .i_nr      (w_nr_lat),
        .i_dec     (r_dec),
        .o_idx     (w_cnt_idx),
        .o_key_idx (w_cnt_key),
        .o_last    (w_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_key_len <= KL128;
            r_dec     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_key_len <= key_len_e'(key_len_i);
                r_dec     <= decrypt_i;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        in_ready_o    = 1'b0;
        out_valid_o   = 1'b0;
        data_ld_o     = 1'b0;
        round_en_o    = 1'b0;
        final_round_o = 1'b0;
        out_ld_o      = 1'b0;
        busy_o        = 1'b0;
        err_o         = 1'b0;
        w_accept      = 1'b0;
        round_idx_o   = '0;
        key_idx_o     = '0;

        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
            end
            ROUND: begin
                round_en_o  = 1'b1;
                busy_o      = 1'b1;
                round_idx_o = w_cnt_idx;
                key_idx_o   = w_cnt_key;
                if (w_last) begin
                    w_state_nxt = FINAL;
                end
            end
            FINAL: begin
                round_en_o    = 1'b1;
                final_round_o = 1'b1;
                out_ld_o      = 1'b1;
                busy_o        = 1'b1;
                round_idx_o   = w_cnt_idx;
                key_idx_o     = w_cnt_key;
                w_state_nxt   = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                round_idx_o = w_cnt_idx;
                key_idx_o   = w_cnt_key;
                if (out_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A rejected offer leaves the state alone; an accepted one overrides it,
        // including the back-to-back case out of DONE.
        if (in_valid_i && in_ready_o) begin
            if (w_legal) begin
                w_accept    = 1'b1;
                data_ld_o   = 1'b1;
                round_idx_o = '0;
                key_idx_o   = decrypt_i ? w_nr_in : '0;
                w_state_nxt = ROUND;
            end else begin
                err_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// tb_aes_round_ctrl : directed self-checking bench for aes_round_ctrl
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    localparam int RW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    key_len;
    logic          decrypt;
    logic          out_ready;

    logic          in_ready, out_valid, data_ld, round_en, final_round, out_ld, busy, err;
    logic [RW-1:0] round_idx, key_idx;

    logic          d2_in_ready, d2_out_valid, d2_data_ld, d2_round_en, d2_final_round;
    logic          d2_out_ld, d2_busy, d2_err;
    logic [RW-1:0] d2_round_idx, d2_key_idx;

    logic [7:0]    w_fl;
    assign w_fl = {in_ready, out_valid, data_ld, round_en, final_round, out_ld, busy, err};

    int n_tests = 0;
    int n_fail  = 0;

    aes_round_ctrl u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .key_len_i     (key_len),
        .decrypt_i     (decrypt),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .data_ld_o     (data_ld),
        .round_en_o    (round_en),
        .final_round_o (final_round),
        .out_ld_o      (out_ld),
        .round_idx_o   (round_idx),
        .key_idx_o     (key_idx),
        .busy_o        (busy),
        .err_o         (err)
    );

    aes_round_ctrl #(
        .KEY_MODES (3'b101)
    ) u_dut2 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (d2_in_ready),
        .key_len_i     (key_len),
        .decrypt_i     (decrypt),
        .out_valid_o   (d2_out_valid),
        .out_ready_i   (out_ready),
        .data_ld_o     (d2_data_ld),
        .round_en_o    (d2_round_en),
        .final_round_o (d2_final_round),
        .out_ld_o      (d2_out_ld),
        .round_idx_o   (d2_round_idx),
        .key_idx_o     (d2_key_idx),
        .busy_o        (d2_busy),
        .err_o         (d2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block (from IDLE, or from DONE when from_done=1) and checks
    // every cycle up to and including the first out_valid cycle.
    task automatic run_block(input logic [1:0] kl, input logic dec, input int nr,
                             input logic from_done, input logic toggle);
        in_valid  = 1'b1;
        key_len   = kl;
        decrypt   = dec;
        out_ready = from_done;
        #1;
        chk("acc_flags", 32'(w_fl), 32'({1'b1, from_done, 1'b1, 5'b0}));
        chk("acc_round_idx", 32'(round_idx), 32'd0);
        chk("acc_key_idx", 32'(key_idx), dec ? 32'(nr) : 32'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= nr; k++) begin
            if (toggle) begin
                key_len = 2'(k);
                decrypt = ~decrypt;
            end
            #1;
            chk("rnd_flags", 32'(w_fl),
                32'({4'b0001, (k == nr), (k == nr), 2'b10}));
            chk("rnd_round_idx", 32'(round_idx), 32'(k));
            chk("rnd_key_idx", 32'(key_idx), dec ? 32'(nr - k) : 32'(k));
            tick();
        end
        chk("done_flags", 32'(w_fl), 32'(8'b0100_0000));
        chk("done_round_idx", 32'(round_idx), 32'(nr));
        key_len = kl;
        decrypt = dec;
    endtask

    initial begin
        logic seen_ov;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        key_len   = 2'd0;
        decrypt   = 1'b0;
        out_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_flags", 32'(w_fl), 32'(8'b1000_0000));
        chk("rst_round_idx", 32'(round_idx), 32'd0);
        chk("rst_key_idx", 32'(key_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // AES-128 encryption
        run_block(2'd0, 1'b0, 10, 1'b0, 1'b0);

        // Backpressure: result held, nothing accepted, no strobes
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            key_len   = 2'd1;
            out_ready = 1'b0;
            #1;
            chk("bp_flags", 32'(w_fl), 32'(8'b0100_0000));
            chk("bp_round_idx", 32'(round_idx), 32'd10);
            tick();
        end

        // Back-to-back AES-192 accepted out of DONE
        run_block(2'd1, 1'b0, 12, 1'b1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("drain_flags", 32'(w_fl), 32'(8'b1100_0000));
        tick();
        out_ready = 1'b0;
        #1;
        chk("idle_flags", 32'(w_fl), 32'(8'b1000_0000));
        tick();

        // AES-256 decryption with inputs toggled mid-flight
        run_block(2'd2, 1'b1, 14, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reserved key length rejected
        in_valid = 1'b1;
        key_len  = 2'd3;
        #1;
        chk("ill_flags", 32'(w_fl), 32'(8'b1000_0001));
        tick();
        in_valid = 1'b0;
        #1;
        chk("ill_after_flags", 32'(w_fl), 32'(8'b1000_0000));

        // AES-192 rejected by an instance with that mode disabled
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        key_len  = 2'd1;
        decrypt  = 1'b0;
        #1;
        chk("dis_err", 32'(d2_err), 32'd1);
        chk("dis_data_ld", 32'(d2_data_ld), 32'd0);
        chk("dis_in_ready", 32'(d2_in_ready), 32'd1);
        chk("en_data_ld", 32'(data_ld), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("dis_busy", 32'(d2_busy), 32'd0);
        chk("dis_err_gone", 32'(d2_err), 32'd0);

        // Asynchronous reset at round 5
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        key_len  = 2'd0;
        decrypt  = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_round_idx", 32'(round_idx), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", 32'(w_fl), 32'(8'b1000_0000));
        chk("arst_round_idx", 32'(round_idx), 32'd0);
        chk("arst_key_idx", 32'(key_idx), 32'd0);
        tick();
        rst_n   = 1'b1;
        seen_ov = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("no_ov_after_rst", 32'(seen_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised round-sequencing controller for the iterative AES datapath. Successor to the fixed AES-128 controller.
- Supports 128/192/256-bit keys (Nr = 10/12/14), encryption and decryption, and a valid/ready handshake on both input and output (output held under backpressure).
- Drives datapath load/advance strobes, the round index and the round-key index. Sits between the bus wrapper and the round datapath plus key-schedule RAM.

Parameters:
- KEY_MODES, 3'b111: enable mask, bit0=128, bit1=192, bit2=256. Disabled modes are rejected.
- MAX_ROUNDS, 14: largest Nr supported. Must be >= Nr of every enabled mode.
- RND_W, $clog2(MAX_ROUNDS+1): width of the round and key index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input block available
- in_ready_o  out  1  controller accepts block
- key_len_i  in  2  0=128, 1=192, 2=256, 3=reserved; sampled at accept
- decrypt_i  in  1  1=decrypt; sampled at accept
- out_valid_o  out  1  result held in output register
- out_ready_i  in  1  downstream accepts result
- data_ld_o  out  1  load input block and apply round-0 AddRoundKey
- round_en_o  out  1  state register advances one round
- final_round_o  out  1  current round skips MixColumns
- out_ld_o  out  1  capture state into output register
- round_idx_o  out  RND_W  current round number, 0..Nr
- key_idx_o  out  RND_W  round-key index for the key RAM
- busy_o  out  1  block in flight (ROUND or FINAL)
- err_o  out  1  one-cycle pulse: offered block rejected

Behaviour:
- Reset values: in_ready_o=1; all other outputs 0; state=IDLE; latched key_len=0; latched decrypt=0.
- Nr per key_len: 0→10, 1→12, 2→14. A mode is illegal if key_len=3 or its KEY_MODES bit is 0.
- Accept condition: in_valid_i & in_ready_o & legal mode.
  - in_ready_o=1 in IDLE.
  - in_ready_o=1 in DONE only when out_ready_i=1 (back-to-back).
  - in_ready_o=0 in ROUND and FINAL.
- Illegal mode: when in_valid_i & in_ready_o with an illegal mode, the block is not accepted, err_o pulses for that cycle and the state does not change. Upstream must drop or change the request.
- State IDLE:
  - On accept: data_ld_o=1, round_idx_o=0, key_idx_o=(dec ? Nr : 0).
  - Latch Nr and decrypt_i, then go to ROUND with round index 1.
- State ROUND:
  - round_en_o=1, busy_o=1.
  - Index increments each cycle. When index==Nr-1, go to FINAL.
- State FINAL:
  - round_en_o=1, final_round_o=1, out_ld_o=1, busy_o=1, round_idx_o=Nr. Go to DONE.
- State DONE:
  - out_valid_o=1; hold until out_ready_i.
  - out_ready_i=1 and accept in the same cycle: data_ld_o=1, go to ROUND (no IDLE bubble).
  - out_ready_i=1 with no accept: go to IDLE.
  - out_ready_i=0: stay in DONE, all strobes 0.
- key_idx_o = round_idx_o for encryption; Nr - round_idx_o for decryption. Subtraction is unsigned in RND_W bits; result is never negative.
- Latency: accept at cycle T → out_valid_o at T+Nr+1. AES-128 = 11, AES-192 = 13, AES-256 = 15.
- Throughput: one block per Nr+1 cycles with back-to-back accept in DONE.
- key_len_i and decrypt_i changing mid-operation have no effect; the latched values rule.
- Reset mid-operation aborts immediately to reset values; no out_valid_o is produced for the aborted block.
- round_idx_o is held (not incremented) in DONE.
- Unreachable state encodings return to IDLE with all strobes 0.

Decomposition:
- Package aes_ctrl_pkg holds:
  - key_len_e enum (KL128, KL192, KL256, KLRSV)
  - ctrl_state_e enum (IDLE, ROUND, FINAL, DONE)
  - function nr_of(key_len_e) returning the Nr constants 10/12/14
  - function mode_legal(key_len, KEY_MODES)
- One sub-module, aes_round_counter: loadable up-counter with terminal compare (index==Nr-1). It also produces key_idx from the latched Nr and decrypt flag.

Test Plan:
- Enc, 128-bit: key_len=0, decrypt=0, in_valid one cycle at T → data_ld at T; round_en high T+1..T+10; final_round and out_ld at T+10; out_valid at T+11; key_idx sequence 0,1..10.
- Dec, 256-bit: key_len=2, decrypt=1 → out_valid at T+15; key_idx sequence 14,13..0; final_round only at round_idx=14.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles in DONE → out_valid held, no strobes, in_ready=0.
  - Then out_ready=1 with in_valid=1 → new data_ld in the same cycle; next out_valid exactly Nr+1 cycles later.
- Illegal mode: key_len=3, or key_len=1 with KEY_MODES=3'b101 → err_o single pulse, in_valid not accepted, state stays IDLE, no data_ld.
- Reset mid-operation: rst_ni low during ROUND at round_idx=5 → all outputs 0 and in_ready=1 immediately (asynchronous); no out_valid afterwards.
- Mid-operation input changes: key_len_i/decrypt_i toggled during ROUND → Nr and key_idx sequence unchanged from the latched values.
